// File: rtl/vend_inventory.sv
// vend_inventory
// Per-product stock store for the vending machine. Each product slot has one
// stock count in a single-port RAM. A small FSM runs every dispense or restock
// request as a read followed by a check and a write. It reports the result and
// keeps registered sold-out and low-stock flags for each slot.
//
// Ports:
//   clk            single clock, rising edge
//   rst            synchronous active-high reset
//   product        slot addressed by dispense_req / restock_req
//   dispense_req   remove one item (held until acknowledged)
//   restock_req    add restock_qty items (held until acknowledged)
//   restock_qty    items to add
//   busy           FSM not idle
//   dispense_ok    pulse: item removed
//   dispense_fail  pulse: slot was empty, nothing changed
//   restock_done   pulse: restock written
//   last_product   slot of the most recent completed operation
//   last_stock     post-operation stock of last_product
//   sold_out       bit i = slot i stock is 0
//   low_stock      bit i = slot i stock in 1..LOW_THRESH
module vend_inventory #(
    parameter int NUM_PRODUCTS = 4,
    parameter int STOCK_W      = 4,
    parameter int INIT_STOCK   = 10,
    parameter int LOW_THRESH   = 2,
    localparam int PW          = $clog2(NUM_PRODUCTS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PW-1:0]           product,
    input  logic                    dispense_req,
    input  logic                    restock_req,
    input  logic [STOCK_W-1:0]      restock_qty,
    output logic                    busy,
    output logic                    dispense_ok,
    output logic                    dispense_fail,
    output logic                    restock_done,
    output logic [PW-1:0]           last_product,
    output logic [STOCK_W-1:0]      last_stock,
    output logic [NUM_PRODUCTS-1:0] sold_out,
    output logic [NUM_PRODUCTS-1:0] low_stock
);

    typedef enum logic [1:0] {INIT, IDLE, DCHK, RCHK} state_t;

    localparam logic [STOCK_W-1:0] MAX_V     = '1;
    localparam logic [STOCK_W-1:0] INIT_V    = STOCK_W'(INIT_STOCK);
    localparam logic [STOCK_W-1:0] LOW_V     = STOCK_W'(LOW_THRESH);
    localparam logic [PW-1:0]      LAST_SLOT = PW'(NUM_PRODUCTS - 1);
    localparam logic               INIT_SOLD = (INIT_V == '0);
    localparam logic               INIT_LOW  = (INIT_V != '0) && (INIT_V <= LOW_V);

    state_t                    state_reg;
    logic [PW-1:0]             ptr_reg;
    logic [PW-1:0]             prod_reg;
    logic [STOCK_W-1:0]        qty_reg;
    logic [STOCK_W-1:0]        rd_data_reg;
    logic                      busy_reg;
    logic                      ok_reg;
    logic                      fail_reg;
    logic                      done_reg;
    logic [PW-1:0]             last_product_reg;
    logic [STOCK_W-1:0]        last_stock_reg;
    logic [NUM_PRODUCTS-1:0]   sold_reg;
    logic [NUM_PRODUCTS-1:0]   low_reg;

    logic [STOCK_W-1:0]        stock_mem [NUM_PRODUCTS];

    logic [STOCK_W:0]          sum_next;
    logic [STOCK_W-1:0]        stock_next;
    logic [PW-1:0]             slot_next;
    logic                      flag_we_next;
    logic                      wr_en_next;
    logic                      rd_en_next;
    logic [NUM_PRODUCTS-1:0]   slot_hit_next;

    // stock_next is the value the slot holds after this cycle's operation.
    // A failed dispense writes nothing, but the slot's flags are still
    // refreshed from the (zero) stock it read.
    always_comb begin
        sum_next     = {1'b0, rd_data_reg} + {1'b0, qty_reg};
        stock_next   = rd_data_reg;
        slot_next    = prod_reg;
        flag_we_next = 1'b0;
        wr_en_next   = 1'b0;
        rd_en_next   = 1'b0;
        if (!rst) begin
            case (state_reg)
                INIT: begin
                    slot_next    = ptr_reg;
                    stock_next   = INIT_V;
                    flag_we_next = 1'b1;
                    wr_en_next   = 1'b1;
                end
                IDLE: rd_en_next = dispense_req | restock_req;
                DCHK: begin
                    flag_we_next = 1'b1;
                    if (rd_data_reg != '0) begin
                        stock_next = rd_data_reg - STOCK_W'(1);
                        wr_en_next = 1'b1;
                    end
                end
                RCHK: begin
                    flag_we_next = 1'b1;
                    wr_en_next   = 1'b1;
                    stock_next   = sum_next[STOCK_W] ? MAX_V : sum_next[STOCK_W-1:0];
                end
                default: ;
            endcase
        end
    end

    // Stock RAM: synchronous write and registered read. A read and a write never
    // happen in the same cycle, so a single port is enough.
    always_ff @(posedge clk) begin
        if (wr_en_next)
            stock_mem[slot_next] <= stock_next;
        if (rd_en_next)
            rd_data_reg <= stock_mem[product];
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PRODUCTS; gi++) begin : g_slot_hit
            assign slot_hit_next[gi] = flag_we_next && (slot_next == PW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sold_reg <= {NUM_PRODUCTS{INIT_SOLD}};
            low_reg  <= {NUM_PRODUCTS{INIT_LOW}};
        end else begin
            for (int i = 0; i < NUM_PRODUCTS; i++) begin
                if (slot_hit_next[i]) begin
                    sold_reg[i] <= (stock_next == '0);
                    low_reg[i]  <= (stock_next != '0) && (stock_next <= LOW_V);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= INIT;
            ptr_reg          <= '0;
            prod_reg         <= '0;
            qty_reg          <= '0;
            busy_reg         <= 1'b1;
            ok_reg           <= 1'b0;
            fail_reg         <= 1'b0;
            done_reg         <= 1'b0;
            last_product_reg <= '0;
            last_stock_reg   <= '0;
        end else begin
            ok_reg   <= 1'b0;
            fail_reg <= 1'b0;
            done_reg <= 1'b0;
            case (state_reg)
                INIT: begin
                    ptr_reg <= ptr_reg + PW'(1);
                    if (ptr_reg == LAST_SLOT) begin
                        ptr_reg   <= '0;
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                IDLE: begin
                    prod_reg <= product;
                    // Dispense wins; a losing restock stays asserted and is
                    // taken on a later visit to IDLE.
                    if (dispense_req) begin
                        state_reg <= DCHK;
                        busy_reg  <= 1'b1;
                    end else if (restock_req) begin
                        qty_reg   <= restock_qty;
                        state_reg <= RCHK;
                        busy_reg  <= 1'b1;
                    end
                end
                DCHK: begin
                    ok_reg           <= (rd_data_reg != '0);
                    fail_reg         <= (rd_data_reg == '0);
                    last_product_reg <= prod_reg;
                    last_stock_reg   <= stock_next;
                    state_reg        <= IDLE;
                    busy_reg         <= 1'b0;
                end
                RCHK: begin
                    done_reg         <= 1'b1;
                    last_product_reg <= prod_reg;
                    last_stock_reg   <= stock_next;
                    state_reg        <= IDLE;
                    busy_reg         <= 1'b0;
                end
                default: begin
                    state_reg <= INIT;
                    ptr_reg   <= '0;
                    busy_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign busy          = busy_reg;
    assign dispense_ok   = ok_reg;
    assign dispense_fail = fail_reg;
    assign restock_done  = done_reg;
    assign last_product  = last_product_reg;
    assign last_stock    = last_stock_reg;
    assign sold_out      = sold_reg;
    assign low_stock     = low_reg;

endmodule

// File: doc/vend_inventory.md
# vend_inventory

Parametrised per-product inventory store for the vending machine. Stock counts live in a single-port register-file RAM with one entry per product slot. A small FSM serialises dispense and restock requests through read-check-write sequences and reports the outcome to the vending controller. It also maintains per-product sold-out and low-stock flags for the display and coin-acceptance logic.

## Interface
- NUM_PRODUCTS, 4, number of product slots (≥2); PW = clog2(NUM_PRODUCTS)
- STOCK_W, 4, bits per stock count; MAX = 2^STOCK_W − 1
- INIT_STOCK, 10, value written to every slot after reset (≤ MAX)
- LOW_THRESH, 2, slot is "low" when 0 < stock ≤ LOW_THRESH

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- product  in  PW  slot addressed by dispense_req / restock_req
- dispense_req  in  1  request to remove one item, held until acknowledged
- restock_req  in  1  request to add restock_qty items, held until acknowledged
- restock_qty  in  STOCK_W  items to add
- busy  out  1  FSM not in IDLE
- dispense_ok  out  1  one-cycle pulse: item removed
- dispense_fail  out  1  one-cycle pulse: slot was empty, nothing changed
- restock_done  out  1  one-cycle pulse: restock written
- last_product  out  PW  slot of most recent completed operation
- last_stock  out  STOCK_W  post-operation stock of last_product
- sold_out  out  NUM_PRODUCTS  bit i = slot i stock is 0
- low_stock  out  NUM_PRODUCTS  bit i = slot i stock in 1..LOW_THRESH

## Operation
- States:
  - INIT: write sweep.
  - IDLE: accept a request.
  - DCHK: dispense check/write.
  - RCHK: restock add/write.
- Reset (rst=1):
  - State → INIT, sweep pointer → 0.
  - busy=1.
  - All pulses 0.
  - last_product=0, last_stock=0.
  - sold_out/low_stock hold the value derived from INIT_STOCK for all bits.
  - Any in-flight operation is dropped with no acknowledge.
- INIT:
  - Each cycle with rst=0, write INIT_STOCK to entry ptr and set that slot's flags; ptr++.
  - After entry NUM_PRODUCTS−1, go to IDLE.
  - Requests are ignored throughout.
- IDLE:
  - Requests are sampled at the clock edge. The RAM read of `product` is issued and the product is latched.
  - dispense_req has priority: go to DCHK.
  - Otherwise restock_req: go to RCHK, latching restock_qty.
  - With neither request, stay in IDLE.
- DCHK:
  - If read stock > 0: write stock−1 and pulse dispense_ok.
  - Else: no write, pulse dispense_fail.
  - Update last_product, last_stock and the slot's flags.
  - Return to IDLE.
- RCHK:
  - Write min(stock + qty, MAX). The sum is computed in STOCK_W+1 bits and then saturated.
  - Pulse restock_done, update last_*/flags, return to IDLE.
- A requester deasserts its req in the cycle its acknowledge is high. A req still high in IDLE is treated as a new request.
- A restock_req losing arbitration to a dispense is not lost; it is served when next sampled in IDLE.
- product and restock_qty need only be stable at the accepting edge.
- Flags are registered and change only on the RAM write of that slot.

## Timing
- Reset release: busy stays 1 for exactly NUM_PRODUCTS cycles after the first cycle with rst=0, then 0.
- Request accepted at edge N (IDLE). busy=1 after edge N. Acknowledge pulse, last_*, flags and busy=0 all appear after edge N+1.
- Request-to-acknowledge latency is 2 edges. Maximum throughput is one operation per 2 cycles.
- The RAM write at edge N+1 is visible to a read issued at edge N+2; no forwarding is needed.
- Exactly one of dispense_ok / dispense_fail / restock_done is high per completed operation. Each is never high for 2 consecutive cycles.

## Test plan
- Reset, defaults → busy=1 for 4 cycles after rst falls; then sold_out=0000, low_stock=0000; dispense slot 0 → dispense_ok, last_stock=9.
- Dispense slot 2 ten times → last_stock 9..0. low_stock[2] rises at stock 2, falls at 0, when sold_out[2]=1. 11th dispense → dispense_fail, last_stock=0, no write.
- Slot 2 at 0, restock qty 7 → restock_done, last_stock=7, sold_out[2]=0. Then restock qty 12 → last_stock=15 (saturated).
- dispense_req and restock_req both high for slot 1 at 10, qty 3 → dispense_ok (9) first, then restock_done (12) two cycles later.
- rst asserted the cycle after a dispense is accepted → no acknowledge pulse; full INIT sweep; all slots read back 10.
- Back-to-back dispenses on slots 0,1,2,3 with req held continuously → acknowledges every 2nd cycle; each slot ends at 9; the other slots are unaffected.
